// File: rtl/i2c_pkg.sv
// Shared constants for the I2C bus arbiter: FSM encoding, bus field widths
// and the read/write direction encoding.
package i2c_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int ST_W = 2;
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LAUNCH   = 2'd1;
   localparam logic [1:0] ST_WAIT     = 2'd2;
   localparam logic [1:0] ST_COMPLETE = 2'd3;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo NREQ; one-hot result, all-zero when nothing requests.
module rr_pick
   import i2c_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int PTR_W = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  winner
);

   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master engine between NREQ requesters, round-robin.
// Optional watchdog on the master engine: define I2C_BUS_ARBITER_TIMEOUT_EN.
module i2c_bus_arbiter
   import i2c_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ-1:0]        req_rw,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        done,
   output logic [DATA_W-1:0]      rdata,
   output logic                   nack,
   output logic                   m_start,
   output logic [ADDR_W-1:0]      m_addr,
   output logic                   m_rw,
   output logic [DATA_W-1:0]      m_wdata,
   input  logic                   m_busy,
   input  logic                   m_done,
   input  logic [DATA_W-1:0]      m_rdata,
   input  logic                   m_nack,
   output logic [ST_W-1:0]        fsm_state
);

   // Handshakes: req is a level held until the arbiter answers; the granted
   // requester gets a single-cycle done with rdata/nack valid in that cycle.
   // Toward the engine, m_start is a one-cycle pulse issued only while
   // m_busy is low, and the engine answers with a one-cycle m_done that is
   // honoured only while waiting for it.

   localparam int PTR_W = ptr_width(NREQ);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] gidx;
   logic [PTR_W-1:0] win_idx;
   logic [NREQ-1:0]  winner;
   logic             expire;

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (winner)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner[i]) win_idx = PTR_W'(i);
      end
   end

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wdog;

   // Counts every cycle spent waiting on the engine; cleared otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog <= '0;
      end else if (fsm_state == ST_LAUNCH || fsm_state == ST_WAIT) begin
         wdog <= wdog + 1'b1;
      end else begin
         wdog <= '0;
      end
   end

   assign expire = (fsm_state == ST_LAUNCH || fsm_state == ST_WAIT) &&
                   (wdog == WD_W'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout;

   assign expire         = 1'b0;
   assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_state <= ST_IDLE;
         gnt       <= '0;
         gidx      <= '0;
         ptr       <= '0;
         m_start   <= 1'b0;
         m_addr    <= '0;
         m_rw      <= 1'b0;
         m_wdata   <= '0;
         rdata     <= '0;
         nack      <= 1'b0;
      end else begin
         m_start <= 1'b0;
         case (fsm_state)
            ST_IDLE: begin
               if (|req) begin
                  gnt       <= winner;
                  gidx      <= win_idx;
                  m_addr    <= req_addr[ADDR_W*win_idx +: ADDR_W];
                  m_rw      <= req_rw[win_idx];
                  m_wdata   <= req_wdata[DATA_W*win_idx +: DATA_W];
                  fsm_state <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               if (expire) begin
                  rdata     <= '0;
                  nack      <= 1'b1;
                  fsm_state <= ST_COMPLETE;
               end else if (!m_busy) begin
                  m_start   <= 1'b1;
                  fsm_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A completion arriving in the expiry cycle beats the watchdog.
               if (m_done) begin
                  rdata     <= m_rdata;
                  nack      <= m_nack;
                  fsm_state <= ST_COMPLETE;
               end else if (expire) begin
                  rdata     <= '0;
                  nack      <= 1'b1;
                  fsm_state <= ST_COMPLETE;
               end
            end
            ST_COMPLETE: begin
               gnt       <= '0;
               ptr       <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
               fsm_state <= ST_IDLE;
            end
            default: begin
               fsm_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign done = (fsm_state == ST_COMPLETE) ? gnt : '0;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a behavioural I2C engine and a
// scoreboard of expected engine starts and requester completions.
module tb_i2c_bus_arbiter;
   import i2c_pkg::*;

   localparam int NREQ = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ-1:0]        req_rw;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        done;
   logic [DATA_W-1:0]      rdata;
   logic                   nack;
   logic                   m_start;
   logic [ADDR_W-1:0]      m_addr;
   logic                   m_rw;
   logic [DATA_W-1:0]      m_wdata;
   logic                   m_busy;
   logic                   m_done;
   logic [DATA_W-1:0]      m_rdata;
   logic                   m_nack;
   logic [ST_W-1:0]        fsm_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   i2c_bus_arbiter #(
      .NREQ        (NREQ),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_addr  (req_addr),
      .req_rw    (req_rw),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .nack      (nack),
      .m_start   (m_start),
      .m_addr    (m_addr),
      .m_rw      (m_rw),
      .m_wdata   (m_wdata),
      .m_busy    (m_busy),
      .m_done    (m_done),
      .m_rdata   (m_rdata),
      .m_nack    (m_nack),
      .fsm_state (fsm_state)
   );

   // ---------------- scoreboard state ----------------
   int n_vec   = 0;
   int n_bad   = 0;
   int n_start = 0;
   int n_done  = 0;

   // done entry: {rdata_care, done[3:0], rdata[7:0], nack}
   logic [13:0] exp_q[$];
   // start entry: {addr[6:0], rw, wdata[7:0]}
   logic [15:0] start_q[$];

   int          mdelay    = 4;
   logic [7:0]  mrd       = 8'h00;
   logic        mnk       = 1'b0;
   logic        master_en = 1'b1;

   logic [13:0] mon_e;
   logic        mon_bad;
   logic [15:0] eng_s;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
      req_addr[7*i +: 7]  = a;
      req_rw[i]           = rw;
      req_wdata[8*i +: 8] = wd;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int c = 0;
      while ((exp_q.size() != 0 || start_q.size() != 0) && c < budget) begin
         @(posedge clk);
         c++;
      end
      n_vec++;
      if (c >= budget) begin
         n_bad++;
         $display("FAIL %s_drain: %0d done and %0d start entries still pending after %0d cycles",
                  name, exp_q.size(), start_q.size(), budget);
         exp_q.delete();
         start_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string name, input logic [3:0] g, input int budget);
      int c = 0;
      while (gnt !== g && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      n_vec++;
      if (gnt !== g) begin
         n_bad++;
         $display("FAIL %s: gnt %b, want %b within %0d cycles", name, gnt, g, budget);
      end
   endtask

   task automatic wait_any_gnt(input string name, input int budget);
      int c = 0;
      while (gnt == '0 && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (gnt == '0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: no grant within %0d cycles", name, budget);
      end
   endtask

   // ---------------- behavioural I2C engine ----------------
   initial begin
      int  d;
      logic aborted;
      m_done  = 1'b0;
      m_rdata = 8'h00;
      m_nack  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst && m_start) begin
            n_start++;
            n_vec++;
            if (start_q.size() == 0) begin
               n_bad++;
               $display("FAIL start_unexpected: addr=%h rw=%b wdata=%h, no start expected",
                        m_addr, m_rw, m_wdata);
            end else begin
               eng_s = start_q.pop_front();
               if ({m_addr, m_rw, m_wdata} !== eng_s) begin
                  n_bad++;
                  $display("FAIL start_fields: got %h want %h", {m_addr, m_rw, m_wdata}, eng_s);
               end
            end
            if (master_en) begin
               d       = mdelay;
               aborted = 1'b0;
               for (int i = 0; i < d && !aborted; i++) begin
                  @(posedge clk);
                  #1;
                  if (!rst) aborted = 1'b1;
               end
               if (!aborted) begin
                  m_done  = 1'b1;
                  m_rdata = mrd;
                  m_nack  = mnk;
                  @(posedge clk);
                  #1;
                  m_done  = 1'b0;
                  m_rdata = 8'h00;
                  m_nack  = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- completion monitor ----------------
   always @(negedge clk) begin
      if (rst && done != '0) begin
         n_done++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL done_unexpected: done=%b rdata=%h nack=%b", done, rdata, nack);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_bad = (done !== mon_e[12:9]) || (gnt !== mon_e[12:9]) ||
                      (nack !== mon_e[0]) || (mon_e[13] && rdata !== mon_e[8:1]);
            if (mon_bad) begin
               n_bad++;
               $display("FAIL done_resp: got done=%b gnt=%b rdata=%h nack=%b want done=%b rdata=%h(care=%b) nack=%b",
                        done, gnt, rdata, nack, mon_e[12:9], mon_e[8:1], mon_e[13], mon_e[0]);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: bench did not finish within 300000 ns");
      $fatal(1, "bench timeout");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int          s0;
      int          d0;
      int          c;
      int          i;
      logic [6:0]  a;
      logic [7:0]  w;
      logic        r;
      logic [3:0]  oh;

      req       = '0;
      req_addr  = '0;
      req_rw    = '0;
      req_wdata = '0;
      m_busy    = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt",     16'(gnt),       16'h0);
      check("rst_done",    16'(done),      16'h0);
      check("rst_m_start", 16'(m_start),   16'h0);
      check("rst_rdata",   16'(rdata),     16'h0);
      check("rst_nack",    16'(nack),      16'h0);
      check("rst_m_addr",  16'(m_addr),    16'h0);
      check("rst_m_rw",    16'(m_rw),      16'h0);
      check("rst_m_wdata", 16'(m_wdata),   16'h0);
      check("rst_state",   16'(fsm_state), 16'(ST_IDLE));
      rst = 1'b1;
      @(posedge clk);
      #1;

      // single read from requester 1, engine answers after 20 cycles
      set_req(1, 7'h57, RW_READ, 8'h00);
      mdelay = 20; mrd = 8'hF5; mnk = 1'b0;
      start_q.push_back({7'h57, 1'b1, 8'h00});
      exp_q.push_back({1'b1, 4'b0010, 8'hF5, 1'b0});
      s0  = n_start;
      req = 4'b0010;
      @(posedge clk);
      #1;
      check("t1_gnt", 16'(gnt), 16'h0002);
      check("t1_no_early_start", 16'(m_start), 16'h0);
      req = 4'b0000;
      set_req(1, 7'h00, RW_WRITE, 8'hFF);
      @(posedge clk);
      #1;
      check("t1_start", 16'(m_start), 16'h1);
      check("t1_addr_hold", 16'(m_addr), 16'h0057);
      check("t1_rw_hold", 16'(m_rw), 16'h1);
      wait_drain("t1", 100);
      check("t1_start_count", 16'(n_start - s0), 16'h1);
      check("t1_rdata_hold", 16'(rdata), 16'h00F5);
      check("t1_gnt_cleared", 16'(gnt), 16'h0);

      // write from requester 3 that the slave NACKs
      set_req(3, 7'h2A, RW_WRITE, 8'h5C);
      mdelay = 5; mrd = 8'h99; mnk = 1'b1;
      start_q.push_back({7'h2A, 1'b0, 8'h5C});
      exp_q.push_back({1'b0, 4'b1000, 8'h00, 1'b1});
      req = 4'b1000;
      wait_gnt("t35_gnt", 4'b1000, 10);
      req = 4'b0000;
      wait_drain("t35", 100);

      // all four requesting; pointer is back at 0 after the grant to 3
      mdelay = 3; mrd = 8'h3C; mnk = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_req(k, 7'(16 + k), k[0], 8'(160 + k));
      end
      for (int k = 0; k < 5; k++) begin
         i  = k % 4;
         a  = 7'(16 + i);
         r  = i[0];
         w  = 8'(160 + i);
         oh = 4'b0001 << i;
         start_q.push_back({a, r, w});
         exp_q.push_back({r, oh, 8'h3C, 1'b0});
      end
      d0  = n_done;
      req = 4'b1111;
      c   = 0;
      while (!(n_done == d0 + 4 && gnt == 4'b0001) && c < 300) begin
         @(posedge clk);
         #1;
         c++;
      end
      req = 4'b0000;
      check("t2_fifth_grant", 16'(gnt), 16'h0001);
      wait_drain("t2", 100);

      // engine busy for 10 cycles after the grant to requester 2
      set_req(2, 7'h33, RW_READ, 8'h00);
      mdelay = 2; mrd = 8'h81; mnk = 1'b0;
      start_q.push_back({7'h33, 1'b1, 8'h00});
      exp_q.push_back({1'b1, 4'b0100, 8'h81, 1'b0});
      m_busy = 1'b1;
      req    = 4'b0100;
      @(posedge clk);
      #1;
      check("t3_gnt", 16'(gnt), 16'h0004);
      req = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("t3_busy_no_start", 16'(m_start), 16'h0);
      end
      m_busy = 1'b0;
      @(posedge clk);
      #1;
      check("t3_start_after_busy", 16'(m_start), 16'h1);
      @(posedge clk);
      #1;
      check("t3_start_single", 16'(m_start), 16'h0);
      wait_drain("t3", 100);

      // reset while waiting on the engine; pointer must restart at 0
      set_req(2, 7'h44, RW_WRITE, 8'h12);
      mdelay = 30;
      start_q.push_back({7'h44, 1'b0, 8'h12});
      req = 4'b0100;
      c   = 0;
      while (!m_start && c < 20) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("t4_started", 16'(m_start), 16'h1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("t4_rst_gnt", 16'(gnt), 16'h0);
      check("t4_rst_done", 16'(done), 16'h0);
      check("t4_rst_m_addr", 16'(m_addr), 16'h0);
      check("t4_rst_state", 16'(fsm_state), 16'(ST_IDLE));
      set_req(1, 7'h21, RW_READ, 8'h00);
      set_req(3, 7'h63, RW_WRITE, 8'h7E);
      mdelay = 4; mrd = 8'h5A; mnk = 1'b0;
      start_q.push_back({7'h21, 1'b1, 8'h00});
      exp_q.push_back({1'b1, 4'b0010, 8'h5A, 1'b0});
      start_q.push_back({7'h63, 1'b0, 8'h7E});
      exp_q.push_back({1'b0, 4'b1000, 8'h00, 1'b0});
      req = 4'b1010;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      wait_any_gnt("t4_regrant", 10);
      check("t4_first_after_reset", 16'(gnt), 16'h0002);
      wait_gnt("t4_second_grant", 4'b1000, 60);
      req = 4'b0000;
      wait_drain("t4", 100);

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
      // engine never answers: watchdog completes with nack
      master_en = 1'b0;
      set_req(0, 7'h0F, RW_READ, 8'h00);
      start_q.push_back({7'h0F, 1'b1, 8'h00});
      exp_q.push_back({1'b1, 4'b0001, 8'h00, 1'b1});
      req = 4'b0001;
      wait_gnt("t5_gnt", 4'b0001, 10);
      req = 4'b0000;
      wait_drain("t5", 100);
      master_en = 1'b1;

      // engine answers in the very cycle the watchdog expires
      mdelay = 14; mrd = 8'h66; mnk = 1'b0;
      start_q.push_back({7'h0F, 1'b1, 8'h00});
      exp_q.push_back({1'b1, 4'b0001, 8'h66, 1'b0});
      req = 4'b0001;
      wait_gnt("t6_gnt", 4'b0001, 10);
      req = 4'b0000;
      wait_drain("t6", 100);
`endif

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one I2C master engine.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, watchdog limit in clk cycles.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester transaction request, level.
REQ-006 SHALL have port req_addr  input  NREQ*7  per-requester 7-bit slave address; requester i uses bits [7i+6:7i].
REQ-007 SHALL have port req_rw  input  NREQ  per-requester direction, 1=read.
REQ-008 SHALL have port req_wdata  input  NREQ*8  per-requester write byte.
REQ-009 SHALL have port gnt  output  NREQ  one-hot grant; at most one bit set.
REQ-010 SHALL have port done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata  output  8  read byte, valid in the done cycle.
REQ-012 SHALL have port nack  output  1  error flag, valid in the done cycle.
REQ-013 SHALL have master-side ports m_start out 1, m_addr out 7, m_rw out 1, m_wdata out 8, m_busy in 1, m_done in 1, m_rdata in 8, m_nack in 1.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT, COMPLETE.
REQ-015 IDLE: if any req bit set, SHALL select the winner round-robin starting at pointer ptr, set gnt, latch addr/rw/wdata into m_addr/m_rw/m_wdata, and go to LAUNCH next cycle.
REQ-016 LAUNCH: when m_busy==0, SHALL pulse m_start for exactly one cycle and go to WAIT; while m_busy==1, SHALL stay in LAUNCH with m_start=0.
REQ-017 WAIT: on m_done==1, SHALL register m_rdata into rdata and m_nack into nack and go to COMPLETE.
REQ-018 COMPLETE: SHALL pulse done[g] for one cycle, clear gnt, set ptr=(g+1) mod NREQ, and return to IDLE.
REQ-019 Latency: req in IDLE at cycle N -> gnt at N+1 -> m_start no earlier than N+2.
REQ-020 m_addr/m_rw/m_wdata SHALL stay stable from grant until COMPLETE regardless of requester inputs.
REQ-021 Deasserting req after grant SHALL NOT abort; the transaction completes and done still pulses.
REQ-022 A requester holding req through done SHALL be re-arbitrated normally; ptr rotation prevents starvation, max wait NREQ-1 transactions.
REQ-023 ptr wrap-around: g==NREQ-1 SHALL set ptr=0.
REQ-024 m_done outside WAIT SHALL be ignored.
REQ-025 rdata SHALL hold its value until the next COMPLETE; for write transactions rdata is don't-care.

Reset
REQ-026 On rst low, SHALL immediately force state=IDLE, gnt=0, done=0, m_start=0, rdata=0, nack=0, m_addr=0, m_rw=0, m_wdata=0, ptr=0, watchdog=0.
REQ-027 Reset mid-transaction SHALL drop the grant with no done pulse.

Configuration
REQ-028 Macro I2C_BUS_ARBITER_TIMEOUT_EN defined: a counter SHALL run in LAUNCH and WAIT; on reaching TIMEOUT_CYC it SHALL go to COMPLETE with nack=1, rdata=0; m_done in the same cycle as expiry SHALL win.
REQ-029 Macro undefined: no counter; LAUNCH and WAIT wait indefinitely; TIMEOUT_CYC unused.

Structure
REQ-030 Shared package i2c_pkg SHALL hold the FSM state encoding, I2C address width 7, data width 8, and the read/write encoding constant.
REQ-031 Round-robin select SHALL be a sub-module rr_pick (inputs req, ptr; output one-hot winner), combinational.

Verification
REQ-032 Single requester: req[1]=1, addr=0x57, rw=1; m_done after 20 cycles with m_rdata=0xF5 -> m_start once, done[1] pulses, rdata=0xF5, nack=0.
REQ-033 All four requesting continuously from ptr=0 -> grant order 0,1,2,3,0, done pulses in that order.
REQ-034 m_busy held high 10 cycles in LAUNCH -> m_start asserted only in the first cycle after m_busy falls.
REQ-035 Write to addr 0x2A with m_nack=1 -> done pulses, nack=1, ptr advances.
REQ-036 rst pulled low in WAIT -> gnt=0 asynchronously, no done; after release, a pending req is granted starting from requester 0.
REQ-037 With TIMEOUT_EN and TIMEOUT_CYC=16, m_done never returned -> done at timeout with nack=1; second run with m_done in the expiry cycle -> nack=m_nack.
